// File: rtl/instr_mem_loader.sv
// Streams program words into the instruction memory from address 0, pads the rest with NO_OP,
// and holds the CPU in reset until the whole image has been written.
module instr_mem_loader #(
  parameter int unsigned       ADDR_W = 10,
  parameter int unsigned       DATA_W = 9,
  parameter int unsigned       DEPTH  = 1024,
  parameter logic [DATA_W-1:0] NO_OP  = 9'b101100100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic              cpu_hold_o
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_DONE
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [ADDR_W-1:0]  ptr_d;
  logic [CNT_W-1:0]   word_count_q;
  logic [CNT_W-1:0]   word_count_d;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               overflow_q;
  logic               done_q;
  logic               cpu_hold_q;
  logic               accept_c;
  logic               at_last_c;

  assign ptr_d        = ptr_q + ADDR_W'(1);
  assign word_count_d = word_count_q + CNT_W'(1);
  assign accept_c     = in_valid_i & (state_q == ST_LOAD);
  assign at_last_c    = (ptr_q == LAST_ADDR);

  // Loader sequencer; every write is issued one cycle after the edge that caused it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
          end else if (state_q == ST_DONE) begin
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_c) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= ptr_q;
            mem_wdata_q  <= in_data_i;
            ptr_q        <= ptr_d;
            word_count_q <= word_count_d;
            if (at_last_c) begin
              state_q    <= ST_DONE;
              overflow_q <= ~in_last_i;
            end else if (in_last_i) begin
              state_q <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= ptr_q;
          mem_wdata_q <= NO_OP;
          ptr_q       <= ptr_d;
          if (at_last_c) begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o   = (state_q == ST_LOAD);
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign word_count_o = word_count_q;
  assign overflow_o   = overflow_q;
  assign done_o       = done_q;
  assign cpu_hold_o   = cpu_hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised bench for instr_mem_loader: a behavioural model predicts every output each cycle,
// and the captured write stream is checked against the expected memory image.
module tb_instr_mem_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 1024;
  localparam int NO_OP  = 'h164;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PAD  = 2;
  localparam int M_DONE = 3;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_last_i;
  logic              in_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [ADDR_W:0]   word_count_o;
  logic              overflow_o;
  logic              done_o;
  logic              cpu_hold_o;

  instr_mem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .word_count_o(word_count_o),
    .overflow_o  (overflow_o),
    .done_o      (done_o),
    .cpu_hold_o  (cpu_hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  int prog [DEPTH];
  int cap_mem [DEPTH];
  int cap_n;
  int first_cyc;
  int first_addr;
  int last_cyc;

  // Behavioural expectations
  int m_mode;
  int m_next;
  int exp_we, exp_addr, exp_wdata, exp_cnt, exp_ovf, exp_done, exp_hold;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_mode = M_IDLE; m_next = 0;
      exp_we = 0; exp_addr = 0; exp_wdata = 0;
      exp_cnt = 0; exp_ovf = 0; exp_done = 0; exp_hold = 1;
    end else begin
      exp_we = 0;
      if (m_mode == M_LOAD) begin
        if (in_valid_i) begin
          exp_we = 1; exp_addr = m_next; exp_wdata = int'(in_data_i);
          exp_cnt = exp_cnt + 1;
          if (m_next == DEPTH - 1) begin
            m_mode = M_DONE;
            exp_ovf = in_last_i ? 0 : 1;
          end else if (in_last_i) begin
            m_mode = M_PAD;
          end
          m_next = m_next + 1;
        end
      end else if (m_mode == M_PAD) begin
        exp_we = 1; exp_addr = m_next; exp_wdata = NO_OP;
        if (m_next == DEPTH - 1) m_mode = M_DONE;
        m_next = m_next + 1;
      end else if (start_i) begin
        m_mode = M_LOAD; m_next = 0;
        exp_cnt = 0; exp_ovf = 0; exp_done = 0; exp_hold = 1;
      end else if (m_mode == M_DONE) begin
        exp_done = 1; exp_hold = 0;
      end
    end
    chk_on = 1'b1;
  end

  // Per-cycle comparison and write capture, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", in_ready_o, (m_mode == M_LOAD) ? 1 : 0);
      chk("mem_we", mem_we_o, exp_we);
      if (exp_we != 0) begin
        chk("mem_addr", mem_addr_o, exp_addr);
        chk("mem_wdata", mem_wdata_o, exp_wdata);
      end
      chk("word_count", word_count_o, exp_cnt);
      chk("overflow", overflow_o, exp_ovf);
      chk("done", done_o, exp_done);
      chk("cpu_hold", cpu_hold_o, exp_hold);
    end
    if (mem_we_o === 1'b1) begin
      if (cap_n == 0) begin
        first_cyc  = cyc;
        first_addr = int'(mem_addr_o);
      end
      cap_mem[mem_addr_o] = int'(mem_wdata_o);
      cap_n    = cap_n + 1;
      last_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    for (int a = 0; a < DEPTH; a++) cap_mem[a] = -1;
    cap_n = 0; first_cyc = -1; first_addr = -1; last_cyc = -1;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) prog[i] = int'($urandom_range(0, 511));
  endtask

  // bubbles: 0 = always valid, 1 = valid on alternate cycles, 2 = random gaps
  task automatic run_load(input int n, input bit with_last, input int bubbles, input bit glitch);
    int i;
    int g;
    bit v;
    bit acc;
    clear_cap();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    i = 0;
    g = 0;
    while (i < n && g < 5000) begin
      case (bubbles)
        0:       v = 1'b1;
        1:       v = (g % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid_i = v;
      in_data_i  = v ? 9'(prog[i]) : 9'($urandom_range(0, 511));
      in_last_i  = v ? (with_last && i == n - 1) : 1'($urandom_range(0, 1));
      start_i    = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = v && in_ready_o;
      step();
      g++;
      if (acc) i++;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    start_i    = 1'b0;
    if (i < n) chk("accept_timeout", i, n);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (done_o !== 1'b1 && g < 1200) begin
      step();
      g++;
    end
    if (done_o !== 1'b1) chk("done_timeout", done_o, 1);
    repeat (3) step();
  endtask

  task automatic check_image(input int n);
    int bad;
    int expv;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      expv = (a < n) ? prog[a] : NO_OP;
      if (cap_mem[a] != expv) begin
        if (bad == 0) $display("FAIL image addr %0d: got %0h expected %0h", a, cap_mem[a], expv);
        bad++;
      end
    end
    chk("image_bad_words", bad, 0);
    chk("image_write_count", cap_n, DEPTH);
    chk("image_first_addr", first_addr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
    clear_cap();

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_cpu_hold", cpu_hold_o, 1);
    chk("rst_word_count", word_count_o, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Three words, no bubbles
    prog[0] = 'h001; prog[1] = 'h002; prog[2] = 'h003;
    run_load(3, 1'b1, 0, 1'b0);
    wait_done();
    check_image(3);
    chk("t2_word0", cap_mem[0], 'h001);
    chk("t2_word2", cap_mem[2], 'h003);
    chk("t2_pad1023", cap_mem[1023], 'h164);
    chk("t2_back_to_back", last_cyc - first_cyc, 1023);
    chk("t2_word_count", word_count_o, 3);
    chk("t2_done", done_o, 1);
    chk("t2_cpu_hold", cpu_hold_o, 0);
    chk("t2_overflow", overflow_o, 0);

    // Same three words with a bubble every other cycle
    run_load(3, 1'b1, 1, 1'b0);
    wait_done();
    check_image(3);
    chk("t3_bubble_span", last_cyc - first_cyc, 1025);
    chk("t3_word_count", word_count_o, 3);

    // Full memory without in_last
    fill_random(DEPTH);
    run_load(DEPTH, 1'b0, 0, 1'b0);
    in_valid_i = 1'b1;
    in_data_i  = 9'h0AA;
    #1;
    chk("t4_extra_not_ready", in_ready_o, 0);
    step();
    in_valid_i = 1'b0;
    wait_done();
    check_image(DEPTH);
    chk("t4_overflow", overflow_o, 1);
    chk("t4_word_count", word_count_o, DEPTH);
    chk("t4_done", done_o, 1);

    // Full memory with in_last on the final word
    fill_random(DEPTH);
    run_load(DEPTH, 1'b1, 2, 1'b0);
    wait_done();
    check_image(DEPTH);
    chk("t5_overflow", overflow_o, 0);
    chk("t5_word_count", word_count_o, DEPTH);

    // Reset in the middle of padding
    fill_random(20);
    run_load(20, 1'b1, 0, 1'b0);
    g = 0;
    while (!(mem_we_o === 1'b1 && mem_addr_o == 10'd500) && g < 1200) begin
      step();
      g++;
    end
    chk("t6_reached_500", mem_addr_o, 500);
    rst_n = 1'b0;
    step();
    chk("t6_rst_mem_we", mem_we_o, 0);
    chk("t6_rst_cpu_hold", cpu_hold_o, 1);
    chk("t6_rst_in_ready", in_ready_o, 0);
    rst_n = 1'b1;
    step();
    fill_random(37);
    run_load(37, 1'b1, 2, 1'b1);
    wait_done();
    check_image(37);
    chk("t6_word_count", word_count_o, 37);

    // Randomised loads with stray start pulses and gaps
    for (int r = 0; r < 5; r++) begin
      int n;
      n = int'($urandom_range(1, 80));
      fill_random(n);
      run_load(n, 1'b1, 2, 1'b1);
      wait_done();
      check_image(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
